dmem_responder: RTL and testbench

- Data-memory responder for the RV32I CPU's load/store port. Executes byte, half and word accesses against an internal word-organised RAM.
- Accepts one request at a time over a valid/ready handshake and returns a response with a fixed, parameterised latency.
- Flags misaligned and out-of-range accesses as faults and keeps a saturating fault count, which feeds the CPU's seg_faults observation output.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_lane_align.sv | 30 +++
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder and its lane aligner.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and load extraction/extension.
// Purely combinational so the fetch path can share it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [31:0] sh;

    always_comb begin
        sh    = rword >> {addr_lo, 3'b000};
        be    = (size == SZ_BYTE) ? 4'b0001 << addr_lo :
                (size == SZ_HALF) ? 4'b0011 << {addr_lo[1], 1'b0} :
                (size == SZ_WORD) ? 4'b1111 : 4'b0000;
        // Replicating the store data puts it on every lane; be picks the live ones.
        wword = (size == SZ_BYTE) ? {4{wdata[7:0]}} :
                (size == SZ_HALF) ? {2{wdata[15:0]}} : wdata;
        rdata = (size == SZ_BYTE) ? {{24{~uns & sh[7]}}, sh[7:0]} :
                (size == SZ_HALF) ? {{16{~uns & sh[15]}}, sh[15:0]} : rword;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I load/store responder with fixed-latency valid/ready response.
// Define DMEM_MMIO_EN to map a word-only MMIO register at MMIO_ADDR.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [7:0]  fault_count,
    output logic [31:0] mmio_out
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WLOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [7:0]  fault_count_q, fault_count_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] off, rword, wword, ldata;
    logic [3:0]  be;
    logic [AW-1:0] idx;
    logic        misalign, fault, is_mmio, mem_we;

    // Unsigned offset: addresses below BASE_ADDR wrap high and fail the span check.
    assign off      = addr_q - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign misalign = (size_q == 2'd3) |
                      ((size_q == SZ_HALF) & addr_q[0]) |
                      ((size_q == SZ_WORD) & (addr_q[1:0] != 2'b00));

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q, mmio_d;
    assign is_mmio  = (addr_q == MMIO_ADDR);
    assign fault    = misalign | (is_mmio ? (size_q != SZ_WORD) : ({1'b0, off} >= SPAN));
    assign rword    = is_mmio ? mmio_q : mem[idx];
    assign mmio_out = mmio_q;
    always_comb mmio_d = (state_q == EXEC && we_q && is_mmio && !fault) ? wdata_q : mmio_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mmio_q <= '0;
        else      mmio_q <= mmio_d;
    end
`else
    assign is_mmio  = 1'b0;
    assign fault    = misalign | ({1'b0, off} >= SPAN);
    assign rword    = mem[idx];
    assign mmio_out = '0;
`endif

    dmem_lane_align u_align (
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .uns     (uns_q),
        .wdata   (wdata_q),
        .rword   (rword),
        .be      (be),
        .wword   (wword),
        .rdata   (ldata)
    );

    assign mem_we = (state_q == EXEC) & we_q & ~fault & ~is_mmio;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        uns_d         = uns_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_fault_d   = rsp_fault_q;
        fault_count_d = fault_count_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                size_d  = req_size;
                uns_d   = req_unsigned;
                cnt_d   = WLOAD;
                state_d = (WAIT_CYCLES > 0) ? WAIT : EXEC;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? EXEC : WAIT;
            end
            EXEC: begin
                state_d       = RESP;
                rsp_fault_d   = fault;
                rsp_rdata_d   = (fault || we_q) ? 32'd0 : ldata;
                fault_count_d = (fault && fault_count_q != 8'hFF) ? fault_count_q + 8'd1 : fault_count_q;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_fault_q   <= 1'b0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_fault_q   <= rsp_fault_d;
            fault_count_q <= fault_count_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_fault   = rsp_fault_q;
    assign fault_count = fault_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata, mmio_out;
    logic [7:0]  fault_count;

    int checks = 0;
    int failures = 0;
    int exp_fc = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .fault_count  (fault_count),
        .mmio_out     (mmio_out)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One request; optionally stalls rsp_ready for 'hold' cycles checking the response is held.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold,
                        input logic [31:0] hold_exp, output logic [31:0] rdata,
                        output logic flt, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) chk("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        flt = rsp_fault;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, hold_exp);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rd, input logic exp_flt);
        logic [31:0] rd;
        logic flt;
        int lat;
        xact(we, addr, wdata, size, uns, 0, 32'd0, rd, flt, lat);
        if (exp_flt) exp_fc = (exp_fc < 255) ? exp_fc + 1 : 255;
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_fault"}, {31'd0, flt}, {31'd0, exp_flt});
        chk({tag, "_fcount"}, {24'd0, fault_count}, 32'(exp_fc));
    endtask

    initial begin
        logic [31:0] rd;
        logic flt;
        int lat;

        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst_fcount", {24'd0, fault_count}, 32'd0);
        chk("rst_mmio", mmio_out, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        run("sw0", 1'b1, 32'h0, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b0);
        run("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0, 1'b0);
        xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 32'h0, rd, flt, lat);
        chk("lw10_rdata", rd, 32'hDEAD_BEEF);
        chk("lw10_fault", {31'd0, flt}, 32'd0);
        chk("lw10_latency", 32'(lat), 32'd3);

        run("lb13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 32'hFFFF_FFDE, 1'b0);
        run("lbu13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 32'h0000_00DE, 1'b0);
        run("lh12", 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 32'hFFFF_DEAD, 1'b0);
        run("lhu10", 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, 32'h0000_BEEF, 1'b0);
        run("lb10", 1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 32'hFFFF_FFEF, 1'b0);

        run("sb11", 1'b1, 32'h11, 32'hFFFF_FF55, 2'd0, 1'b0, 32'h0, 1'b0);
        run("lw10_sb", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD_55EF, 1'b0);
        run("sh12", 1'b1, 32'h12, 32'h9999_ABCD, 2'd1, 1'b0, 32'h0, 1'b0);
        run("lw10_sh", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hABCD_55EF, 1'b0);
        run("sw20", 1'b1, 32'h20, 32'h0BAD_C0DE, 2'd2, 1'b0, 32'h0, 1'b0);

        run("lw12_mis", 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1);
        run("sw_oor", 1'b1, 32'h1000, 32'h1111_1111, 2'd2, 1'b0, 32'h0, 1'b1);
        run("lw0_intact", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0);
        run("size3", 1'b0, 32'h20, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1);
        run("lh11_mis", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1);
        run("lw_top", 1'b0, 32'hFFFF_FFFC, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1);

`ifdef DMEM_MMIO_EN
        run("mmio_sw", 1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, 2'd2, 1'b0, 32'h0, 1'b0);
        chk("mmio_out", mmio_out, 32'h0000_00A5);
        run("mmio_lw", 1'b0, 32'hFFFF_FFF0, 32'h0, 2'd2, 1'b0, 32'h0000_00A5, 1'b0);
        run("mmio_lb", 1'b0, 32'hFFFF_FFF0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
`else
        run("mmio_sw", 1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, 2'd2, 1'b0, 32'h0, 1'b1);
        chk("mmio_out", mmio_out, 32'h0);
`endif

        for (int i = 0; i < 300; i++)
            run("sat", 1'b0, 32'h0, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1);
        chk("fcount_sat", {24'd0, fault_count}, 32'd255);

        xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, 32'hABCD_55EF, rd, flt, lat);
        chk("hold_final_rdata", rd, 32'hABCD_55EF);
        @(negedge clk);
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Abort a store to 0x20 while it sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF;
        req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        chk("abort_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("abort_fcount", {24'd0, fault_count}, 32'd0);
        chk("abort_mmio", mmio_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_fc = 0;
        run("lw20_after_abort", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h0BAD_C0DE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
